// File: rtl/uvmc_xbar_pkg.sv
// uvmc_xbar_pkg
// Shared helpers for the packet crossbar: index/level width functions,
// default-configuration width constants and the round-robin picker used by
// the per-consumer arbiters.
package uvmc_xbar_pkg;

  // Widest producer count the round-robin picker handles.
  localparam int MAX_PROD = 32;

  // Index width for n channels; a single channel still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy width for a FIFO holding 0..depth entries.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Widths for the default 2x2, depth-4 configuration.
  localparam int PROD_IW = 1;
  localparam int CONS_IW = 1;
  localparam int LVL_W   = 3;

  // One-hot grant: first set bit of req scanning upward from ptr,
  // wrapping modulo n.
  function automatic logic [MAX_PROD-1:0] rr_pick(
    input logic [MAX_PROD-1:0] req,
    input int                  ptr,
    input int                  n
  );
    logic [MAX_PROD-1:0] g;
    logic                found;
    int                  idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_PROD; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[4:0]]) begin
          g[idx[4:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/uvmc_xbar_fifo.sv
// uvmc_xbar_fifo
// Per-consumer synchronous FIFO, no empty bypass (push visible next cycle).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push, push_data  write strobe and beat; caller guarantees space
//   pop              consumer ready; ignored while empty
//   valid, data      head valid and head beat (held while not popped)
//   level            occupancy 0..DEPTH
module uvmc_xbar_fifo
  import uvmc_xbar_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [DATA_W-1:0]        data,
  output logic [lvl_w(DEPTH)-1:0]  level
);

  localparam int AW = idx_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_q;
  logic [AW-1:0]     wr_q;
  logic [LW-1:0]     lvl_q;
  logic              do_pop;

  assign do_pop = pop && (lvl_q != '0);

  // DEPTH is a power of two, so the pointers wrap naturally.
  // Storage is cleared on reset so the head reads 0 while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) begin
        mem[wr_q] <= push_data;
        wr_q      <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      if (push && !do_pop)      lvl_q <= lvl_q + LW'(1);
      else if (!push && do_pop) lvl_q <= lvl_q - LW'(1);
    end
  end

  assign valid = (lvl_q != '0);
  assign data  = mem[rd_q];
  assign level = lvl_q;

endmodule

// File: rtl/uvmc_pkt_xbar.sv
// uvmc_pkt_xbar
// N_PROD x N_CONS packet crossbar with a runtime binding table, a
// round-robin arbiter per consumer and a FIFO per consumer.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cfg_we/cfg_prod/cfg_cons/cfg_en   binding-table write (next-cycle effect)
//   in_valid/in_ready/in_data         producer beats, DATA_W slice per producer
//   out_valid/out_ready/out_data      consumer FIFO heads, DATA_W slice each
//   out_level                         per-consumer occupancy
//   unbound_err                       sticky: valid seen on an unbound producer
module uvmc_pkt_xbar
  import uvmc_xbar_pkg::*;
#(
  parameter int N_PROD = 2,
  parameter int N_CONS = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_we,
  input  logic [idx_w(N_PROD)-1:0]         cfg_prod,
  input  logic [idx_w(N_CONS)-1:0]         cfg_cons,
  input  logic                             cfg_en,
  input  logic [N_PROD-1:0]                in_valid,
  output logic [N_PROD-1:0]                in_ready,
  input  logic [N_PROD*DATA_W-1:0]         in_data,
  output logic [N_CONS-1:0]                out_valid,
  input  logic [N_CONS-1:0]                out_ready,
  output logic [N_CONS*DATA_W-1:0]         out_data,
  output logic [N_CONS*lvl_w(DEPTH)-1:0]   out_level,
  output logic                             unbound_err
);

  localparam int P_IW = idx_w(N_PROD);
  localparam int C_IW = idx_w(N_CONS);
  localparam int L_W  = lvl_w(DEPTH);

  logic [N_PROD-1:0]   bound_q;
  logic [C_IW-1:0]     dest_q    [N_PROD];
  logic [P_IW-1:0]     ptr_q     [N_CONS];
  logic                err_q;

  logic                cfg_ok;
  logic [N_PROD-1:0]   blocked;
  logic [MAX_PROD-1:0] req       [N_CONS];
  logic [MAX_PROD-1:0] grant     [N_CONS];
  logic [N_CONS-1:0]   space;
  logic [N_CONS-1:0]   push;
  logic [DATA_W-1:0]   push_data [N_CONS];
  logic [P_IW-1:0]     next_ptr  [N_CONS];

  assign cfg_ok = cfg_we && (int'(cfg_prod) < N_PROD) && (int'(cfg_cons) < N_CONS);

  always_ff @(posedge clk) begin
    if (rst) begin
      bound_q <= '0;
      for (int p = 0; p < N_PROD; p++) dest_q[p] <= '0;
      for (int c = 0; c < N_CONS; c++) ptr_q[c] <= '0;
      err_q   <= 1'b0;
    end else begin
      if (cfg_ok) begin
        bound_q[cfg_prod] <= cfg_en;
        dest_q[cfg_prod]  <= cfg_cons;
      end
      if (|(in_valid & ~bound_q)) err_q <= 1'b1;
      // Priority only moves when a beat actually transfers.
      for (int c = 0; c < N_CONS; c++)
        if (push[c]) ptr_q[c] <= next_ptr[c];
    end
  end

  always_comb begin
    blocked = '0;
    for (int p = 0; p < N_PROD; p++)
      blocked[p] = cfg_we && (int'(cfg_prod) == p);
  end

  // A producer in its own config-write cycle drops out of arbitration, so the
  // grant can go to another requester instead of being wasted.
  always_comb begin
    for (int c = 0; c < N_CONS; c++) begin
      req[c]       = '0;
      next_ptr[c]  = '0;
      push_data[c] = '0;
      for (int p = 0; p < N_PROD; p++)
        if (in_valid[p] && bound_q[p] && (int'(dest_q[p]) == c) && !blocked[p])
          req[c][p] = 1'b1;
      grant[c] = rr_pick(req[c], int'(ptr_q[c]), N_PROD);
      // Push into a full FIFO is legal when the head leaves this cycle.
      space[c] = (int'(out_level[c*L_W +: L_W]) < DEPTH) ||
                 ((int'(out_level[c*L_W +: L_W]) == DEPTH) && out_valid[c] && out_ready[c]);
      push[c]  = (|grant[c]) && space[c];
      for (int p = 0; p < N_PROD; p++)
        if (grant[c][p]) begin
          push_data[c] = in_data[p*DATA_W +: DATA_W];
          next_ptr[c]  = (p == N_PROD - 1) ? '0 : P_IW'(p + 1);
        end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int p = 0; p < N_PROD; p++)
      for (int c = 0; c < N_CONS; c++)
        if (grant[c][p] && space[c]) in_ready[p] = 1'b1;
  end

  assign unbound_err = err_q;

  for (genvar c = 0; c < N_CONS; c++) begin : g_cons
    uvmc_xbar_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[c]),
      .push_data (push_data[c]),
      .pop       (out_ready[c]),
      .valid     (out_valid[c]),
      .data      (out_data[c*DATA_W +: DATA_W]),
      .level     (out_level[c*L_W +: L_W])
    );
  end

endmodule

// File: doc/uvmc_pkt_xbar.md
# uvmc_pkt_xbar

Parametrised synthesizable packet crossbar for the connections examples. It generalises the single named producer-to-consumer binding into N_PROD producer channels and N_CONS consumer channels. A runtime binding table maps each producer to one consumer, replacing name matching with a numeric key, and each consumer has its own buffer. It sits between stimulus producers and DUT-side consumers in emulation-friendly benches, where a fixed point-to-point connect is too rigid.

## Interface
Parameters:
- N_PROD, 2: number of producer channels (≥1)
- N_CONS, 2: number of consumer channels (≥1)
- DATA_W, 32: packet beat width in bits
- DEPTH, 4: per-consumer FIFO depth; power of two, ≥2

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  binding-table write strobe
- cfg_prod  in  max(1,$clog2(N_PROD))  producer index to bind
- cfg_cons  in  max(1,$clog2(N_CONS))  destination consumer index
- cfg_en  in  1  1 binds the producer, 0 unbinds it
- in_valid  in  N_PROD  per-producer beat valid
- in_ready  out  N_PROD  per-producer beat accept
- in_data  in  N_PROD*DATA_W  producer beats; producer p occupies slice [p*DATA_W +: DATA_W]
- out_valid  out  N_CONS  per-consumer FIFO head valid
- out_ready  in  N_CONS  consumer accept
- out_data  out  N_CONS*DATA_W  consumer FIFO heads, sliced the same way
- out_level  out  N_CONS*$clog2(DEPTH+1)  per-consumer FIFO occupancy
- unbound_err  out  1  sticky: a producer asserted valid while unbound

## Operation
- Binding table: bound[p] and dest[p] per producer.
  - A cfg_we write takes effect on the next cycle.
  - Out-of-range cfg_prod or cfg_cons: write ignored.
- Transfer rules:
  - A beat transfers on in_valid[p] & in_ready[p].
  - It is written into FIFO dest[p].
  - Beats from one producer stay in order.
- in_ready[p] = bound[p] & grant[p] & space(dest[p]) & !(cfg_we & cfg_prod==p).
  - Ready is forced low on a producer in its own config-write cycle, so a rebind never splits a beat.
- Arbitration, per consumer:
  - Round-robin among bound producers with in_valid.
  - At most one grant per consumer per cycle.
  - After granting p, priority starts at (p+1) mod N_PROD.
  - Pointer resets to 0.
  - in_ready may depend combinationally on in_valid. Producers must not depend on ready to raise valid.
- Space rule: space(c) = level<DEPTH, or (level==DEPTH & out_valid[c] & out_ready[c]), i.e. push on a full FIFO is allowed when a pop happens in the same cycle.
- Consumer side:
  - out_valid[c] = level!=0.
  - Pop on out_valid & out_ready.
  - out_data holds its value while valid & !ready.
- Simultaneous push and pop: level unchanged.
- Pop with ready on empty: no effect.
- unbound_err sets when in_valid[p] & !bound[p]. Only rst clears it. The beat is not accepted; ready stays 0.
- Unbinding a producer does not flush beats already queued for it.
- Reset, including mid-operation:
  - FIFOs flush, all producers unbound, pointers to 0.
  - out_valid=0, out_level=0, in_ready=0, unbound_err=0.
  - out_data = 0.

## Timing
- Push-to-out_valid latency: 1 cycle; there is no empty bypass.
- Throughput: 1 beat/cycle per consumer. Aggregate is up to min(N_PROD,N_CONS) beats/cycle.
- Pointers are read and written with wrap modulo DEPTH. Level is held in $clog2(DEPTH+1) bits.
- A config write in cycle t: the new binding is used for the arbiter request from t+1.
- in_ready and out_valid are valid in the cycle after rst deasserts. in_ready still needs a binding before it can rise.

## Structure
- Package uvmc_xbar_pkg holds:
  - helper constants PROD_IW, CONS_IW, LVL_W
  - function rr_pick(req, ptr) returning a one-hot grant
- Sub-module uvmc_xbar_fifo: synchronous FIFO, parameters DATA_W and DEPTH, instantiated once per consumer.
- Binding table, per-consumer arbiters and the ready muxing live in the top.

## Test plan
- Reset, bind p0→c1, push 0xA5A5_0001 then 0xA5A5_0002 with out_ready=1 → out_valid[1] rises 1 cycle after each push, data in order, c0 never valid.
- Unbound producer: p1 valid, no binding → in_ready[1]=0, unbound_err=1 next cycle and stays 1 until rst.
- Contention: p0 and p1 both bound to c0, both valid continuously → grants alternate p0,p1,p0,p1 starting with p0 after reset.
- Full/backpressure, DEPTH=4, out_ready=0: 4 beats accepted, level=4, in_ready=0. Then out_ready=1 with valid held → a push and a pop in the same cycle, level stays 4.
- Rebind: cfg write p0→c0 in the same cycle as p0 valid → no accept that cycle. The beat lands in c0 next cycle, and earlier beats remain queued in c1.
- Reset mid-stream, with FIFO c0 at level 3 → the cycle after rst: level 0, out_valid 0, bindings cleared.
